// File: rtl/uart_tx_drain.sv
// UART transmitter that drains a byte FIFO and serialises each byte as
// start, DBIT data bits (LSB first), optional parity and stop bit(s).
module uart_tx_drain #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       tx_busy
);

    localparam int TICK_MAX = (SB_TICK > 16) ? SB_TICK - 1 : 15;
    localparam int TW       = $clog2(TICK_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [2:0]      bit_q, bit_d;
    logic [DBIT-1:0] shreg_q, shreg_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            tick_last;
    logic            stop_last;

    assign tick_last = s_tick && (tick_q == TW'(15));
    assign stop_last = s_tick && (tick_q == TW'(SB_TICK - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        fifo_rd = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd = reset;
                    shreg_d = fifo_data[DBIT-1:0];
                    tick_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick_last) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else if (s_tick) begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_DATA: begin
                if (tick_last) begin
                    tick_d  = '0;
                    par_d   = par_q ^ shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    if (bit_q == 3'(DBIT - 1)) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else if (s_tick) begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (tick_last) begin
                    tick_d  = '0;
                    state_d = S_STOP;
                end else if (s_tick) begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_STOP: begin
                if (stop_last) begin
                    tick_d  = '0;
                    par_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (s_tick) begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The line level is registered from the state being entered, so
        // every bit starts exactly on the edge that begins it.
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
            S_PARITY: tx_d = (PARITY == 1) ? ~par_d : par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != S_IDLE);

endmodule
